// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants and clamp helper for the stopwatch datapath
package stopwatch_pkg;

  localparam int DIGIT_W_DEF = 4;

  // Packed per-digit maxima, digit 0 in the low nibble.
  localparam logic [15:0] MMSS_MAX = {4'd5, 4'd9, 4'd5, 4'd9};
  localparam logic [15:0] HHMM_MAX = {4'd2, 4'd9, 4'd5, 4'd9};

  function automatic int unsigned clamp_digit(input int unsigned value, input int unsigned max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/mod_digit.sv
// rtl/mod_digit.sv - one modulo-(MAX+1) up/down digit with clamped reset and load
module mod_digit
  import stopwatch_pkg::*;
#(
  parameter int          W   = DIGIT_W_DEF,
  parameter int unsigned MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] reset_val,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         up_dn,
  output logic [W-1:0] count,
  output logic         thr
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] reset_clamp;
  logic [W-1:0] load_clamp;
  logic [W-1:0] next;

  assign reset_clamp = W'(clamp_digit(32'(reset_val), MAX));
  assign load_clamp  = W'(clamp_digit(32'(load_val), MAX));

  // Terminal is relative to the direction currently requested.
  assign thr = up_dn ? (count == MAX_V) : (count == '0);

  always_comb begin
    next = count;
    if (up_dn) begin
      next = (count == MAX_V) ? '0 : count + W'(1);
    end else begin
      next = (count == '0) ? MAX_V : count - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= reset_clamp;
    end else if (load) begin
      count <= load_clamp;
    end else if (step) begin
      count <= next;
    end
  end

endmodule

// File: rtl/cascade_time_counter.sv
// rtl/cascade_time_counter.sv - cascaded multi-digit up/down time counter with wrap/stop modes
module cascade_time_counter
  import stopwatch_pkg::*;
#(
  parameter int                              NUM_DIGITS = 4,
  parameter int                              DIGIT_W    = DIGIT_W_DEF,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   MAX_VALS   = MMSS_MAX,
  parameter int                              WRAP_MODE  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            up_dn,
  input  logic                            load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   load_val,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   reset_val,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   count,
  output logic [NUM_DIGITS-1:0]           digit_thr,
  output logic                            terminal,
  output logic                            wrap_pulse
);

  localparam bit WRAP_EN = (WRAP_MODE != 0);

  // chain[i] is high when every digit below i sits at its terminal value.
  logic [NUM_DIGITS:0]   chain;
  logic [NUM_DIGITS-1:0] step;
  logic                  advance;

  assign chain[0] = 1'b1;
  assign terminal = chain[NUM_DIGITS];

  // In stop mode a tick at the whole-chain terminal is swallowed.
  assign advance = enable & ~load & (WRAP_EN | ~terminal);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign chain[i+1] = chain[i] & digit_thr[i];
    assign step[i]    = advance & chain[i];

    mod_digit #(
      .W   (DIGIT_W),
      .MAX (32'(MAX_VALS[i*DIGIT_W +: DIGIT_W]))
    ) u_digit (
      .clk       (clk),
      .reset     (reset),
      .reset_val (reset_val[i*DIGIT_W +: DIGIT_W]),
      .load      (load),
      .load_val  (load_val[i*DIGIT_W +: DIGIT_W]),
      .step      (step[i]),
      .up_dn     (up_dn),
      .count     (count[i*DIGIT_W +: DIGIT_W]),
      .thr       (digit_thr[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_pulse <= 1'b0;
    end else if (load) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= enable & terminal & WRAP_EN;
    end
  end

endmodule

// File: tb/tb_cascade_time_counter.sv
// tb/tb_cascade_time_counter.sv - scoreboard bench for cascade_time_counter in wrap and stop modes
module tb_cascade_time_counter;
  import stopwatch_pkg::*;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam logic [15:0] MAXV = 16'h5959;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        up_dn = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] reset_val = '0;

  logic [15:0] count_w, count_h;
  logic [3:0]  thr_w, thr_h;
  logic        term_w, term_h, wp_w, wp_h;

  cascade_time_counter #(.NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_VALS(MAXV), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .reset_val(reset_val), .count(count_w),
    .digit_thr(thr_w), .terminal(term_w), .wrap_pulse(wp_w)
  );

  cascade_time_counter #(.NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_VALS(MAXV), .WRAP_MODE(0)) u_hold (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .reset_val(reset_val), .count(count_h),
    .digit_thr(thr_h), .terminal(term_h), .wrap_pulse(wp_h)
  );

  // Reference model: the whole display is one mixed-radix integer in 0..period-1.
  int          maxv[ND];
  int unsigned period;
  int unsigned n_w, n_h;
  logic        mwp_w, mwp_h;

  typedef struct {
    logic [15:0] c_w; logic [3:0] t_w; logic tm_w; logic p_w;
    logic [15:0] c_h; logic [3:0] t_h; logic tm_h; logic p_h;
  } exp_t;
  exp_t q[$];

  int n_err = 0;
  int n_chk = 0;

  function automatic int unsigned clamp_val(input logic [15:0] v);
    int unsigned acc = 0;
    int unsigned w = 1;
    for (int i = 0; i < ND; i++) begin
      int d;
      d = int'(v[i*DW +: DW]);
      if (d > maxv[i]) d = maxv[i];
      acc += d * w;
      w *= maxv[i] + 1;
    end
    return acc;
  endfunction

  function automatic logic [15:0] to_packed(input int unsigned n);
    logic [15:0] p = '0;
    int unsigned r = n;
    for (int i = 0; i < ND; i++) begin
      p[i*DW +: DW] = 4'(r % (maxv[i] + 1));
      r = r / (maxv[i] + 1);
    end
    return p;
  endfunction

  function automatic logic [3:0] thr_of(input int unsigned n, input logic ud);
    logic [3:0] t = '0;
    int unsigned r = n;
    for (int i = 0; i < ND; i++) begin
      int d;
      d = int'(r % (maxv[i] + 1));
      r = r / (maxv[i] + 1);
      t[i] = ud ? (d == maxv[i]) : (d == 0);
    end
    return t;
  endfunction

  function automatic logic at_end(input int unsigned n, input logic ud);
    return ud ? (n == period - 1) : (n == 0);
  endfunction

  task automatic push_exp();
    exp_t e;
    e.c_w = to_packed(n_w); e.t_w = thr_of(n_w, up_dn); e.tm_w = at_end(n_w, up_dn); e.p_w = mwp_w;
    e.c_h = to_packed(n_h); e.t_h = thr_of(n_h, up_dn); e.tm_h = at_end(n_h, up_dn); e.p_h = mwp_h;
    q.push_back(e);
  endtask

  task automatic model_edge();
    if (load) begin
      n_w = clamp_val(load_val); n_h = n_w; mwp_w = 1'b0; mwp_h = 1'b0;
    end else if (enable) begin
      mwp_w = at_end(n_w, up_dn);
      n_w = up_dn ? (n_w + 1) % period : (n_w + period - 1) % period;
      mwp_h = 1'b0;
      if (!at_end(n_h, up_dn)) n_h = up_dn ? n_h + 1 : n_h - 1;
    end else begin
      mwp_w = 1'b0; mwp_h = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic en, input logic ud, input logic ld, input logic [15:0] lv);
    @(negedge clk);
    reset = 1'b0; enable = en; up_dn = ud; load = ld; load_val = lv;
    @(posedge clk);
    #1;
    model_edge();
    push_exp();
  endtask

  // Reset is raised between clock edges so its effect must be seen before the next edge.
  task automatic do_reset(input logic [15:0] rv);
    @(negedge clk);
    reset = 1'b0;
    reset_val = rv;
    #2 reset = 1'b1;
    #1;
    n_w = clamp_val(rv); n_h = n_w; mwp_w = 1'b0; mwp_h = 1'b0;
    push_exp();
    @(posedge clk);
    #1;
    push_exp();
  endtask

  always @(posedge clk or posedge reset) begin
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("count_wrap",    32'(count_w), 32'(e.c_w));
      chk("thr_wrap",      32'(thr_w),   32'(e.t_w));
      chk("terminal_wrap", 32'(term_w),  32'(e.tm_w));
      chk("pulse_wrap",    32'(wp_w),    32'(e.p_w));
      chk("count_hold",    32'(count_h), 32'(e.c_h));
      chk("thr_hold",      32'(thr_h),   32'(e.t_h));
      chk("terminal_hold", 32'(term_h),  32'(e.tm_h));
      chk("pulse_hold",    32'(wp_h),    32'(e.p_h));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ud;
    logic [15:0] lv;
    int          r;

    period = 1;
    for (int i = 0; i < ND; i++) begin
      maxv[i] = int'(MAXV[i*DW +: DW]);
      period *= maxv[i] + 1;
    end
    n_w = 0; n_h = 0; mwp_w = 1'b0; mwp_h = 1'b0;

    do_reset(16'h1234);
    cycle(1'b0, 1'b1, 1'b1, 16'h0559);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b1, 16'h5959);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 16'h1000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 16'h0001);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b1, 16'h7999);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b1, 16'h5957);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    do_reset(16'h0258);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 16'h0000);

    ud = 1'b1;
    repeat (400) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset(16'($urandom));
      end else begin
        if ($urandom_range(0, 9) == 0) ud = ~ud;
        case ($urandom_range(0, 3))
          0:       lv = 16'($urandom);
          1:       lv = 16'h5959;
          2:       lv = 16'h0000;
          default: lv = ud ? 16'h5958 : 16'h0001;
        endcase
        cycle($urandom_range(0, 3) != 0, ud, r < 10, lv);
      end
    end

    @(posedge clk);
    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
